// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encodings,
// column idle pattern, key-code layout and counter sizing helpers.
package keypad_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  // Bits needed to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Lowest-indexed active-low row bit.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] make_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    key_code_t k;
    k.row = row;
    k.col = col;
    return k;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-high (no key).
module keypad_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Optional auto-repeat when KEYPAD_REPEAT_EN is defined.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = cnt_w(SCAN_DIV);
  localparam int BW = cnt_w(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 ||
      REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    $error("keypad_scan4x4: parameters must be >= 1");
  end

  logic [3:0]    rows_s;
  logic [1:0]    state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [DW-1:0] dwell;
  logic [BW-1:0] cnt;
  logic          bit_low;
  logic          rpt_fire;

  keypad_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rows_s)
  );

  assign bit_low = ~rows_s[row_idx];
  assign col     = ~((~COL_IDLE) << col_idx);

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = cnt_w(RMAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  logic [RW-1:0] rpt;
  logic          rpt_first;

  assign rpt_fire = (state == ST_PRESSED) && bit_low &&
                    (rpt_first ? (rpt >= PER_LAST) : (rpt >= DLY_LAST));

  // Counter lives only while PRESSED; any bounce through RELEASE restarts it.
  always_ff @(posedge clk) begin
    if (rst || state != ST_PRESSED) begin
      rpt       <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_fire) begin
      rpt       <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt <= rpt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell     <= '0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        ST_SCAN: begin
          if (dwell >= DWELL_LAST) begin
            dwell <= '0;
            if (rows_s != 4'hF) begin
              row_idx <= first_low(rows_s);
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!bit_low) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            state   <= ST_SCAN;
          end else if (cnt >= DB_LAST) begin
            cnt       <= '0;
            key_code  <= make_code(row_idx, col_idx);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= ST_PRESSED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!bit_low) begin
            cnt   <= BW'(1);
            state <= ST_RELEASE;
          end else if (rpt_fire) begin
            key_valid <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (bit_low) begin
            cnt   <= '0;
            state <= ST_PRESSED;
          end else if (cnt >= DB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            state    <= ST_SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with a behavioural 4x4 key matrix.
// Repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_scan4x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys = '0;

  int passed = 0;
  int total  = 0;
  int t      = 0;
  int nvalid = 0;
  int at [8];
  logic [3:0] vcode = 4'h0;

  keypad_scan4x4 #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8),
    .REPEAT_DLY   (20),
    .REPEAT_PER   (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row[r] = ~|(keys[r] & ~col);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      if (key_valid) begin
        if (nvalid < 8) at[nvalid] = t;
        nvalid++;
        vcode = key_code;
      end
    end
  endtask

  task automatic do_reset();
    keys = '0;
    rst  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    t      = 0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) at[i] = 0;
  endtask

  initial begin
    // 1: idle scan
    do_reset();
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    run(4); check("scan_c1", col, 4'b1101);
    run(4); check("scan_c2", col, 4'b1011);
    run(4); check("scan_c3", col, 4'b0111);
    run(4); check("scan_c0", col, 4'b1110);
    check("idle_nvalid", nvalid, 0);
    check("idle_held", key_held, 1'b0);

    // 2: key (2,2): DEBOUNCE at edge 12, accept at 20
    do_reset();
    keys[2][2] = 1'b1;
    run(30);
    check("k22_nvalid", nvalid, 1);
    check("k22_at", at[0], 20);
    check("k22_vcode", vcode, 4'hA);
    check("k22_code", key_code, 4'hA);
    check("k22_held", key_held, 1'b1);
    keys = '0;
    run(12);
    check("k22_rel_held", key_held, 1'b0);
    check("k22_rel_nvalid", nvalid, 1);

    // 3: short press on (0,0) aborted in DEBOUNCE
    do_reset();
    keys[0][0] = 1'b1;
    run(6);
    check("short_frozen", col, 4'b1110);
    keys = '0;
    run(4);
    check("short_next_col", col, 4'b1101);
    run(4);
    check("short_scan_on", col, 4'b1011);
    check("short_nvalid", nvalid, 0);
    check("short_held", key_held, 1'b0);

    // 4: key (1,3), accept at 24, release bounce then final release
    do_reset();
    keys[1][3] = 1'b1;
    run(30);
    check("k13_at", at[0], 24);
    check("k13_code", key_code, 4'h7);
    keys = '0;
    run(3);
    keys[1][3] = 1'b1;
    run(3);
    check("bounce_held", key_held, 1'b1);
    keys = '0;
    run(9);
    check("rel_held_pre", key_held, 1'b1);
    run(1);
    check("rel_held_drop", key_held, 1'b0);
    check("rel_col_next", col, 4'b1110);
    check("rel_code_hold", key_code, 4'h7);
    check("k13_nvalid", nvalid, 1);

    // 5: two rows on col1, lowest row wins; then reset mid-DEBOUNCE
    do_reset();
    keys[1][1] = 1'b1;
    keys[3][1] = 1'b1;
    run(20);
    check("multi_at", at[0], 16);
    check("multi_code", key_code, 4'h5);
    keys = '0;
    run(10);
    check("multi_rel_held", key_held, 1'b0);
    check("multi_rel_col", col, 4'b1011);
    keys[3][2] = 1'b1;
    run(6);
    check("db_frozen", col, 4'b1011);
    check("db_code_hold", key_code, 4'h5);
    rst = 1'b1;
    run(1);
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_nvalid", nvalid, 1);

    // 6: key (2,1) held 45 clk past accept at 16
    do_reset();
    keys[2][1] = 1'b1;
    run(61);
    check("hold_first", at[0], 16);
    check("hold_code", vcode, 4'h9);
`ifdef KEYPAD_REPEAT_EN
    check("rep_nvalid", nvalid, 4);
    check("rep_at1", at[1], 36);
    check("rep_at2", at[2], 46);
    check("rep_at3", at[3], 56);
`else
    check("norep_nvalid", nvalid, 1);
`endif
    check("hold_held", key_held, 1'b1);
    keys = '0;
    run(12);
    check("hold_rel_held", key_held, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
